// File: rtl/alu_dp_sequencer_if.sv
// Bus bundle for alu_dp_sequencer: instruction handshake, register-file
// ports, ALU drive/capture, retirement pulses and the FSM debug view.
//
// Handshake: an instruction transfers on a rising clock edge where both
// instr_valid_in and instr_ready_out are high. instr_ready_out depends only
// on the sequencer state, never on instr_valid_in, and instr_valid_in is
// ignored whenever instr_ready_out is low.
interface alu_dp_sequencer_if #(
  parameter int RF_AW = 4,
  parameter int DW    = 32
);
  logic [31:0]      instr_in;
  logic             instr_valid_in;
  logic             instr_ready_out;
  logic [RF_AW-1:0] rf_raddr_a_out;
  logic [RF_AW-1:0] rf_raddr_b_out;
  logic [DW-1:0]    rf_rdata_a_in;
  logic [DW-1:0]    rf_rdata_b_in;
  logic             rf_we_out;
  logic [RF_AW-1:0] rf_waddr_out;
  logic [DW-1:0]    rf_wdata_out;
  logic [DW-1:0]    alu_a_out;
  logic [DW-1:0]    alu_b_out;
  logic [3:0]       alu_cmd_out;
  logic [1:0]       alu_sh_out;
  logic [4:0]       alu_shamt5_out;
  logic             alu_i_out;
  logic             alu_s_out;
  logic [DW-1:0]    alu_result_in;
  logic [3:0]       alu_nzcv_in;
  logic [3:0]       flags_out;
  logic             done_out;
  logic             skipped_out;
  logic             illegal_out;
  logic [1:0]       state_dbg_out;

  modport slave (
    input  instr_in, instr_valid_in, rf_rdata_a_in, rf_rdata_b_in,
           alu_result_in, alu_nzcv_in,
    output instr_ready_out, rf_raddr_a_out, rf_raddr_b_out, rf_we_out,
           rf_waddr_out, rf_wdata_out, alu_a_out, alu_b_out, alu_cmd_out,
           alu_sh_out, alu_shamt5_out, alu_i_out, alu_s_out, flags_out,
           done_out, skipped_out, illegal_out, state_dbg_out
  );

  modport master (
    output instr_in, instr_valid_in, rf_rdata_a_in, rf_rdata_b_in,
           alu_result_in, alu_nzcv_in,
    input  instr_ready_out, rf_raddr_a_out, rf_raddr_b_out, rf_we_out,
           rf_waddr_out, rf_wdata_out, alu_a_out, alu_b_out, alu_cmd_out,
           alu_sh_out, alu_shamt5_out, alu_i_out, alu_s_out, flags_out,
           done_out, skipped_out, illegal_out, state_dbg_out
  );
endinterface

// File: rtl/alu_dp_sequencer.sv
// alu_dp_sequencer: serial issue/writeback sequencer for the combinational
// CPU ALU. One instruction at a time walks IDLE -> READ -> EXEC -> WB.
// Illegal instructions jump IDLE -> WB and only pulse illegal_out.
// Optional feature macro: CPU_ALU_COND_EN (condition-code evaluation).
// Without it every cond value behaves as AL and skipped_out stays 0.
module alu_dp_sequencer #(
  parameter int RF_AW = 4,
  parameter int DW    = 32
) (
  input logic            clk_in,
  input logic            rst_n_in,
  alu_dp_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [3:0] CMD_SHIFT = 4'b1101;

  state_t        state_q, state_d;
  logic          accept;
  logic          instr_legal;
  logic [25:0]   instr_q;      // I, cmd, S, Rn, Rd, src2 of the held instruction
  logic          illegal_q;
  logic [DW-1:0] result_q;
  logic [3:0]    nzcv_q;
  logic [3:0]    flags_q;
  logic          cond_pass;

  // Field views of the held instruction.
  logic          i_f, s_f;
  logic [3:0]    cmd_f, rn_f, rd_f, rm_f, rot_f;
  logic [7:0]    imm8_f;
  logic [1:0]    sh_f;
  logic [4:0]    shamt_f;

  assign i_f     = instr_q[25];
  assign cmd_f   = instr_q[24:21];
  assign s_f     = instr_q[20];
  assign rn_f    = instr_q[19:16];
  assign rd_f    = instr_q[15:12];
  assign rot_f   = instr_q[11:8];
  assign shamt_f = instr_q[11:7];
  assign sh_f    = instr_q[6:5];
  assign imm8_f  = instr_q[7:0];
  assign rm_f    = instr_q[3:0];

  function automatic logic cmd_supported(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1101: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Legality is judged on the incoming word so an illegal one never reaches READ.
  assign instr_legal = (bus.instr_in[27:26] == 2'b00) && cmd_supported(bus.instr_in[24:21]);

  // Rotated immediate: imm8 rotated right by twice the 4-bit rotate field.
  logic [DW-1:0]   imm_ext;
  logic [2*DW-1:0] imm_dbl;
  logic [4:0]      rot2;
  logic [DW-1:0]   rot_imm;

  assign imm_ext = {{(DW-8){1'b0}}, imm8_f};
  assign rot2    = {rot_f, 1'b0};
  assign imm_dbl = {imm_ext, imm_ext} >> rot2;
  assign rot_imm = imm_dbl[DW-1:0];

`ifdef CPU_ALU_COND_EN
  logic [3:0] cond_q;
  logic       fl_n, fl_z, fl_c, fl_v;

  assign {fl_n, fl_z, fl_c, fl_v} = flags_q;

  // Hold the condition field alongside the rest of the instruction.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)   cond_q <= '0;
    else if (accept) cond_q <= bus.instr_in[31:28];
  end

  // Condition check against the flags as they stand before this retirement.
  always_comb begin
    cond_pass = 1'b0;
    case (cond_q)
      4'h0:    cond_pass = fl_z;
      4'h1:    cond_pass = !fl_z;
      4'h2:    cond_pass = fl_c;
      4'h3:    cond_pass = !fl_c;
      4'h4:    cond_pass = fl_n;
      4'h5:    cond_pass = !fl_n;
      4'h6:    cond_pass = fl_v;
      4'h7:    cond_pass = !fl_v;
      4'h8:    cond_pass = fl_c && !fl_z;
      4'h9:    cond_pass = !fl_c || fl_z;
      4'hA:    cond_pass = (fl_n == fl_v);
      4'hB:    cond_pass = (fl_n != fl_v);
      4'hC:    cond_pass = !fl_z && (fl_n == fl_v);
      4'hD:    cond_pass = fl_z || (fl_n != fl_v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  assign cond_pass = 1'b1;
`endif

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic: fixed walk, illegal words short-cut to WB.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid_in) begin
          accept  = 1'b1;
          state_d = instr_legal ? S_READ : S_WB;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: latch on accept, capture ALU in EXEC, flags in WB.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      instr_q   <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      nzcv_q    <= '0;
      flags_q   <= '0;
    end else begin
      if (accept) begin
        instr_q   <= bus.instr_in[25:0];
        illegal_q <= !instr_legal;
      end
      if (state_q == S_EXEC) begin
        result_q <= bus.alu_result_in;
        nzcv_q   <= bus.alu_nzcv_in;
      end
      if ((state_q == S_WB) && !illegal_q && cond_pass && s_f) begin
        flags_q <= nzcv_q;
      end
    end
  end

  // Outputs decoded from the state; everything idles at zero.
  always_comb begin
    bus.instr_ready_out = 1'b0;
    bus.rf_raddr_a_out  = '0;
    bus.rf_raddr_b_out  = '0;
    bus.rf_we_out       = 1'b0;
    bus.rf_waddr_out    = '0;
    bus.rf_wdata_out    = '0;
    bus.alu_a_out       = '0;
    bus.alu_b_out       = '0;
    bus.alu_cmd_out     = '0;
    bus.alu_sh_out      = '0;
    bus.alu_shamt5_out  = '0;
    bus.alu_i_out       = 1'b0;
    bus.alu_s_out       = 1'b0;
    bus.done_out        = 1'b0;
    bus.skipped_out     = 1'b0;
    bus.illegal_out     = 1'b0;
    case (state_q)
      S_IDLE: bus.instr_ready_out = 1'b1;
      S_READ: begin
        bus.rf_raddr_a_out = RF_AW'(rn_f);
        bus.rf_raddr_b_out = RF_AW'(rm_f);
      end
      S_EXEC: begin
        // Shift/move feeds the shifted source on A and the amount on B.
        if (cmd_f == CMD_SHIFT) begin
          bus.alu_a_out = i_f ? rot_imm : bus.rf_rdata_b_in;
          bus.alu_b_out = {{(DW-5){1'b0}}, shamt_f};
        end else begin
          bus.alu_a_out = bus.rf_rdata_a_in;
          bus.alu_b_out = i_f ? rot_imm : bus.rf_rdata_b_in;
        end
        bus.alu_cmd_out    = cmd_f;
        bus.alu_sh_out     = sh_f;
        bus.alu_shamt5_out = shamt_f;
        bus.alu_i_out      = i_f;
        bus.alu_s_out      = s_f;
      end
      S_WB: begin
        if (illegal_q) begin
          bus.illegal_out = 1'b1;
        end else begin
          bus.done_out    = 1'b1;
          bus.skipped_out = !cond_pass;
          if (cond_pass) begin
            bus.rf_we_out    = 1'b1;
            bus.rf_waddr_out = RF_AW'(rd_f);
            bus.rf_wdata_out = result_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.flags_out     = flags_q;
  assign bus.state_dbg_out = state_q;

endmodule

// File: doc/alu_dp_sequencer.md
Name: alu_dp_sequencer

Overview:
- Issue/writeback sequencer that drives the combinational CPU ALU.
- Accepts 32-bit data-processing instructions over a valid/ready handshake and decodes them.
- Reads operands from an external synchronous register file, presents operands and command to the ALU, then captures the result.
- Writes back Rd, updates the architectural NZCV register when S=1, and evaluates condition codes against the held flags.

Parameters:
- RF_AW, 4, register-file address width (16 registers)
- DW, 32, datapath width

Ports:
- clk_in  in  1  clock, all state changes on rising edge
- rst_n_in  in  1  synchronous reset, active-low
- instr_in  in  32  instruction: cond[31:28] op[27:26] I[25] cmd[24:21] S[20] Rn[19:16] Rd[15:12] src2[11:0]
- instr_valid_in  in  1  instruction valid
- instr_ready_out  out  1  high only in IDLE
- rf_raddr_a_out  out  4  read address A
- rf_raddr_b_out  out  4  read address B
- rf_rdata_a_in  in  32  read data A, valid the cycle after the address
- rf_rdata_b_in  in  32  read data B, valid the cycle after the address
- rf_we_out  out  1  write enable, one-cycle pulse
- rf_waddr_out  out  4  write address (Rd)
- rf_wdata_out  out  32  write data
- alu_a_out  out  32  ALU A operand
- alu_b_out  out  32  ALU B operand
- alu_cmd_out  out  4  ALU command
- alu_sh_out  out  2  shift type
- alu_shamt5_out  out  5  shift amount
- alu_i_out  out  1  immediate flag
- alu_s_out  out  1  set-flags flag
- alu_result_in  in  32  ALU result
- alu_nzcv_in  in  4  ALU flags, bit3=N bit2=Z bit1=C bit0=V
- flags_out  out  4  architectural NZCV, same bit order as alu_nzcv_in
- done_out  out  1  pulse: instruction retired (written or skipped)
- skipped_out  out  1  pulse with done_out: condition failed
- illegal_out  out  1  pulse: illegal instruction dropped

Behaviour:
- Reset (rst_n_in=0 at an edge): state=IDLE; flags_out=0; all pulses, rf_we_out and ALU outputs 0; latched instruction cleared. A reset in any state aborts the instruction with no register or flag write.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: instr_ready_out=1. On valid&ready, latch instr_in and go to READ.
- READ: drive rf_raddr_a_out=Rn and rf_raddr_b_out=Rm (src2[3:0]).
- EXEC: rf_rdata valid. Drive ALU outputs combinationally; register alu_result_in and alu_nzcv_in at the end of the cycle.
- WB: if the condition passes, assert rf_we_out with rf_waddr_out=Rd and rf_wdata_out=captured result; if S=1, also load flags_out from the captured nzcv on the same edge. Pulse done_out. Next state IDLE.
- Timing: 4 cycles per instruction, accept edge to next ready. instr_valid_in is ignored outside IDLE.
- Operand rules, cmd != 1101: A=Rn value. B=Rm value (I=0), or B=imm8 rotated right by 2*src2[11:8] (I=1).
- Operand rules, cmd 1101 (shift/move): A=Rm value (I=0) or the rotated immediate (I=1). B={27'b0, src2[11:7]}.
- alu_sh_out=src2[6:5]; alu_shamt5_out=src2[11:7]; alu_i_out=I; alu_s_out=S. The ALU outputs are 0 outside EXEC.
- Supported cmd: 0000, 0001, 0100, 0101, 0110, 0111, 1101.
- Illegal: op!=00 or unsupported cmd, detected at accept. Go straight from IDLE to a one-cycle WB with illegal_out=1, no write, no flag update, done_out=0.
- Condition codes, evaluated in WB against flags_out before the update:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1110 always; 1111 never
- Condition fail: no rf write, no flag update, done_out=1 and skipped_out=1.
- Rd=Rn and Rd=Rm are allowed. Any register hazard is resolved by the serial FSM, so no forwarding is needed.

Optional Feature:
- CPU_ALU_COND_EN defined: condition evaluation as above.
- Undefined: every cond value, including 1111, is treated as AL. skipped_out is tied to 0.

Test Plan:
- RF r1=5, r2=7; instr 0xE0913002 (ADDS r3,r1,r2); ALU model returns 12/nzcv 0000 -> cycle 1 raddr 1/2, cycle 2 alu_a=5 alu_b=7 cmd=0100 s=1, cycle 3 we=1 waddr=3 wdata=12, flags_out=0000, done=1; ready high cycle 4.
- instr 0xE3A004FF (cmd 1101, I=1, imm 0xFF ror 8) -> alu_a_out=0xFF000000, alu_i_out=1, rf write r0=ALU result, flags unchanged (S=0).
- flags_out=0100 (Z=1): issue EQ op (cond 0000) -> write occurs; then NE op (cond 0001) -> rf_we_out=0, done=1, skipped=1; with CPU_ALU_COND_EN undefined, the NE op writes.
- instr 0x0C000000 (op=11) -> illegal_out=1 at cycle 1, no rf_we, ready at cycle 2; same for cmd 1010.
- Assert rst_n_in=0 during EXEC of an ADDS -> next cycle IDLE, rf_we never asserted, flags_out=0000, ready=1.
- Hold instr_valid_in high with back-to-back instructions -> accepts spaced exactly 4 cycles, each retired once.
